// File: rtl/dm_access.sv
// Memory-stage data access unit: request/ack data-memory bus master with byte enables and load extension.
// Optional feature macro: DM_MISALIGN_TRAP_EN (trap misaligned word/half accesses instead of truncating).
module dm_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        MemWrite,
  input  logic        MEMRead,
  input  logic [2:0]  DMType,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [2:0]    type_q;
  logic [1:0]    off_q;

  logic          req;
  logic          is_half;
  logic          is_byte;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [15:0]   lane_h;
  logic [7:0]    lane_b;
  logic [31:0]   load_d;

  assign req   = MemWrite | MEMRead;
  assign stall = ((state == IDLE) && req) || (state == WAIT);

  // Half uses only addr[1] and word ignores addr[1:0], so truncation falls out naturally.
  always_comb begin
    is_half = (DMType == 3'b001) || (DMType == 3'b010);
    is_byte = (DMType == 3'b011) || (DMType == 3'b100);
    be_d    = 4'b1111;
    wdata_d = wdata;
    if (is_half) begin
      be_d    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{wdata[15:0]}};
    end else if (is_byte) begin
      be_d    = 4'b0001 << addr[1:0];
      wdata_d = {4{wdata[7:0]}};
    end
  end

`ifdef DM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
`endif

  always_comb begin
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    lane_b = bus_rdata[{off_q, 3'b000} +: 8];
    case (type_q)
      3'b001:  load_d = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_d = {16'h0000, lane_h};
      3'b011:  load_d = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_d = {24'h000000, lane_b};
      default: load_d = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      type_q    <= '0;
      off_q     <= '0;
      rvalid    <= 1'b0;
      fault     <= 1'b0;
      rdata     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      rvalid <= 1'b0;
      fault  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q   <= MemWrite;
            type_q <= DMType;
            off_q  <= addr[1:0];
`ifdef DM_MISALIGN_TRAP_EN
            if (misalign) begin
              state  <= DONE;
              rvalid <= 1'b1;
              fault  <= 1'b1;
              rdata  <= '0;
            end else
`endif
            begin
              bus_req   <= 1'b1;
              bus_we    <= MemWrite;
              bus_addr  <= addr[31:2];
              bus_be    <= be_d;
              bus_wdata <= wdata_d;
              cnt       <= '0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          // A late ack on the final permitted cycle still wins over the timeout.
          if (bus_ack) begin
            bus_req <= 1'b0;
            rvalid  <= 1'b1;
            if (!we_q) rdata <= load_d;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            bus_req <= 1'b0;
            rvalid  <= 1'b1;
            fault   <= 1'b1;
            rdata   <= '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access.sv
// Self-checking bench for dm_access: directed and randomized accesses against a byte-level reference model.
module tb_dm_access;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MEMRead = 1'b0;
  logic [2:0]  DMType = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .MemWrite(MemWrite), .MEMRead(MEMRead), .DMType(DMType),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .rvalid(rvalid), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // One access: cycle 0 presents the request; delay = WAIT cycles without ack before ack (>= TMO means never).
  task automatic do_access(input logic wr, input logic rd, input logic [2:0] typ,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int unsigned delay, input logic [31:0] word);
    int unsigned n, off, exp_cyc, k;
    logic        sgn, mis, exp_fault, done;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, mask, v, exp_rd;
    n   = (typ == 3'd1 || typ == 3'd2) ? 2 : (typ == 3'd3 || typ == 3'd4) ? 1 : 4;
    sgn = (typ == 3'd1 || typ == 3'd3);
    off = a[1:0] & ~(n - 1);
    exp_be = 4'((32'd1 << n) - 1) << off;
    exp_wd = (n == 4) ? wd : (n == 2) ? wd[15:0] * 32'h0001_0001 : wd[7:0] * 32'h0101_0101;
`ifdef DM_MISALIGN_TRAP_EN
    mis = (a % n) != 0;
`else
    mis = 1'b0;
`endif
    mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
    v = (word >> (8 * off)) & mask;
    if (sgn && v[8 * n - 1]) v = v | ~mask;
    exp_fault = mis || (delay >= TMO);
    exp_rd    = exp_fault ? 32'd0 : v;
    exp_cyc   = mis ? 1 : (delay < TMO) ? delay + 2 : TMO + 1;

    @(posedge clk); #1;
    MemWrite = wr; MEMRead = rd; DMType = typ; addr = a; wdata = wd;
    bus_ack = 1'($urandom % 2); bus_rdata = $urandom;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_c0: got %b want 1", stall); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL bus_req_c0: got %b want 0", bus_req); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_c0: got %b want 0", rvalid); end

    k = 0; done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      k++;
      if (rvalid === 1'b1) begin
        done = 1'b1;
        checks++; if (k != exp_cyc) begin errors++; $display("FAIL rvalid_cycle: got %0d want %0d", k, exp_cyc); end
        checks++; if (fault !== exp_fault) begin errors++; $display("FAIL fault: got %b want %b", fault, exp_fault); end
        if (exp_fault || !wr) begin
          checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL rdata: got %h want %h", rdata, exp_rd); end
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_done: got %b want 0", stall); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL bus_req_done: got %b want 0", bus_req); end
        bus_ack = 1'($urandom % 2); bus_rdata = $urandom;
      end else begin
        if (k >= exp_cyc) begin
          errors++; checks++;
          $display("FAIL rvalid_missing: got 0 at cycle %0d want 1 at cycle %0d", k, exp_cyc);
          if (k > exp_cyc + 3) done = 1'b1;
        end
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL bus_req_wait: got %b want 1", bus_req); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_wait: got %b want 1", stall); end
        checks++; if (bus_we !== wr) begin errors++; $display("FAIL bus_we: got %b want %b", bus_we, wr); end
        checks++; if (bus_addr !== a[31:2]) begin errors++; $display("FAIL bus_addr: got %h want %h", bus_addr, a[31:2]); end
        checks++; if (bus_be !== exp_be) begin errors++; $display("FAIL bus_be: got %b want %b", bus_be, exp_be); end
        if (wr) begin
          checks++; if (bus_wdata !== exp_wd) begin errors++; $display("FAIL bus_wdata: got %h want %h", bus_wdata, exp_wd); end
        end
        if (k == delay + 1) begin bus_ack = 1'b1; bus_rdata = word; end
        else begin bus_ack = 1'b0; bus_rdata = $urandom; end
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    MemWrite = 1'b0; MEMRead = 1'b0; bus_ack = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_idle: got %b want 0", rvalid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b want 0", stall); end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    checks++; if ({rvalid, fault, bus_req, bus_we} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {rvalid, fault, bus_req, bus_we}); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    checks++; if ({bus_addr, bus_be, bus_wdata} !== 66'd0) begin errors++; $display("FAIL rst_bus: got %h/%h/%h want 0", bus_addr, bus_be, bus_wdata); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    do_access(1'b0, 1'b1, 3'd0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b1, 3'd3, 32'h0000_0103, 32'h0, 1, 32'h80FF_0000);
    do_access(1'b0, 1'b1, 3'd4, 32'h0000_0103, 32'h0, 2, 32'h80FF_0000);
    do_access(1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h1234_ABCD, 3, 32'h0);
    do_access(1'b0, 1'b1, 3'd0, 32'h0000_0200, 32'h0, 99, 32'h0);
    do_access(1'b0, 1'b1, 3'd1, 32'h0000_0101, 32'h0, 0, 32'h1234_8765);
    do_access(1'b1, 1'b1, 3'd3, 32'h0000_0301, 32'hA5A5_A53C, 0, 32'hFFFF_FFFF);
    do_access(1'b0, 1'b1, 3'd7, 32'h0000_0404, 32'h0, 0, 32'h0BAD_F00D);
    go_idle();
  endtask

  task automatic test_random();
    logic wr, rd;
    int unsigned dly;
    for (int i = 0; i < 60; i++) begin
      wr  = 1'($urandom % 2);
      rd  = wr ? 1'($urandom % 2) : 1'b1;
      dly = ($urandom % 8 == 0) ? 99 : $urandom_range(0, TMO - 1);
      do_access(wr, rd, 3'($urandom % 8), $urandom, $urandom, dly, $urandom);
      if ($urandom % 4 == 0) go_idle();
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    MemWrite = 1'b0; MEMRead = 1'b1; DMType = 3'd0; addr = 32'h0000_0500; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL mid_bus_req: got %b want 1", bus_req); end
    rstn = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL mid_async_drop: got %b want 0", bus_req); end
    MEMRead = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({rvalid, bus_req} !== 2'b00) begin errors++; $display("FAIL mid_quiet: got %b want 00", {rvalid, bus_req}); end
    end
    rstn = 1'b1;
    do_access(1'b0, 1'b1, 3'd0, 32'h0000_0100, 32'h0, 0, 32'hCAFE_F00D);
    go_idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_access.md
# dm_access

Memory-stage data access unit for the pipelined RV32I core. It consumes the decoder's memory controls (MemWrite, MEMRead, DMType) and the EX/MEM address and store data. It drives a word-wide request/acknowledge data-memory bus with byte enables, and returns a sign- or zero-extended load result. While an access is outstanding, it holds the pipeline with a stall.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for bus_ack before the access is abandoned (must be ≥ 1)

Ports:
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous active-low reset
- MemWrite  in  1  store request from EX/MEM register
- MEMRead  in  1  load request from EX/MEM register
- DMType  in  3  access size/sign: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101–111 treated as word
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  holds PC, IF/ID, ID/EX, EX/MEM while high
- rdata  out  32  extended load data, valid when rvalid=1
- rvalid  out  1  one-cycle pulse: access completed (load or store)
- fault  out  1  one-cycle pulse with rvalid: misaligned access or bus timeout
- bus_req  out  1  request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  30  word address (addr[31:2])
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  completion, sampled only while bus_req=1
- bus_rdata  in  32  read word, valid with bus_ack

## Operation
- The FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - A request is MemWrite|MEMRead.
  - If both are high, the access is a write and the read is ignored.
  - On a request, the unit latches we, DMType, addr[1:0], word address, byte enables and replicated data, then moves to WAIT.
  - With no request, it stays in IDLE.
- Byte enables:
  - Word: 1111.
  - Half: addr[1] ? 1100 : 0011.
  - Byte: 0001 << addr[1:0].
- Store data replication:
  - Half: {wdata[15:0], wdata[15:0]}.
  - Byte: {4{wdata[7:0]}}.
- WAIT:
  - bus_req=1 and all bus outputs are stable.
  - On bus_ack: if the access is a load, capture the selected lane and extend it per DMType into rdata; then move to DONE.
  - A cycle counter increments in WAIT. When it reaches TIMEOUT without ack, the unit moves to DONE with fault=1, and rdata is 0.
- DONE:
  - rvalid=1 and stall=0 for exactly one cycle, so the pipeline advances; then the unit returns to IDLE.
  - The DONE→IDLE transition ignores the request inputs that are still present this cycle (the same instruction). New requests are accepted only from IDLE.
- stall = (IDLE & request) | WAIT.
- Load extension:
  - Half signed replicates bit 15; byte signed replicates bit 7.
  - Unsigned variants zero-fill.
  - The lane is selected by the latched addr[1:0].

## Timing
- Reset values: FSM=IDLE, counter=0, stall=0, rvalid=0, fault=0, rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
- Minimum latency:
  - The request is seen in cycle 0; bus_req is high from cycle 1.
  - If ack arrives in cycle 1, rvalid/rdata appear in cycle 2.
  - stall is high in cycles 0–1.
- Each extra wait cycle adds one cycle of latency.
- Timeout: fault is asserted in cycle TIMEOUT+1 after the request.
- Reset mid-access drops bus_req immediately (asynchronously). No completion is reported.
- A bus_ack received in IDLE or DONE is ignored.

## Configuration
- DM_MISALIGN_TRAP_EN defined:
  - A word access with addr[1:0]≠00, or a half access with addr[0]=1, issues no bus request.
  - IDLE→DONE directly, with fault=1 and rdata=0.
  - stall is high for one cycle.
- DM_MISALIGN_TRAP_EN undefined:
  - Low address bits are silently truncated: word uses addr[1:0]=00, half uses addr[0]=0.
  - fault is only produced by timeout.

## Test plan
- lw at 0x100, ack in 1st WAIT cycle with bus_rdata=0xDEADBEEF -> bus_addr=0x40, be=1111, rdata=0xDEADBEEF in cycle 2, stall high for 2 cycles.
- lb at 0x103, rdata word 0x80FF_0000 -> be=1000, rdata=0xFFFFFF80; lbu at the same address -> 0x00000080.
- sh at 0x102, wdata=0x1234ABCD, ack after 3 wait cycles -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, rvalid in cycle 5, bus signals stable throughout.
- lw with no ack, TIMEOUT=4 -> fault and rvalid pulse in cycle 5, rdata=0, unit returns to IDLE.
- lh at 0x101 with DM_MISALIGN_TRAP_EN -> no bus_req, fault in cycle 1; without the macro -> be=0011 at word 0x40.
- rstn low during WAIT -> bus_req=0 at once, no rvalid; next lw after reset completes normally.
